logic_gate_unit: RTL and testbench



---
 rtl/logic_gate_unit.sv | 81 ++++++++
 tb/tb_logic_gate_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/logic_gate_unit.sv
// Registered bit-wise AND / NAND / NOR of two operand vectors.
// One capture stage qualified by in_valid; asynchronous active-high reset.

module and_gate (
    output logic out,
    input  logic in1,
    input  logic in2
);
    assign out = in1 & in2;
endmodule

module nand_gate (
    output logic out,
    input  logic in1,
    input  logic in2
);
    assign out = ~(in1 & in2);
endmodule

module nor_gate (
    output logic out,
    input  logic in1,
    input  logic in2
);
    assign out = ~(in1 | in2);
endmodule

module logic_gate_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] o_and,
    output logic [WIDTH-1:0] o_nand,
    output logic [WIDTH-1:0] o_nor,
    output logic             out_valid
);

    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] nand_bits;
    logic [WIDTH-1:0] nor_bits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and_gate u_and (
            .out (and_bits[i]),
            .in1 (a[i]),
            .in2 (b[i])
        );
        nand_gate u_nand (
            .out (nand_bits[i]),
            .in1 (a[i]),
            .in2 (b[i])
        );
        nor_gate u_nor (
            .out (nor_bits[i]),
            .in1 (a[i]),
            .in2 (b[i])
        );
    end

    // All-zero reset state intentionally breaks nand == ~and; only valid data obeys it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_and     <= '0;
            o_nand    <= '0;
            o_nor     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                o_and  <= and_bits;
                o_nand <= nand_bits;
                o_nor  <= nor_bits;
            end
        end
    end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit: WIDTH=1 exhaustive truth table and a WIDTH=16
// instance checked every cycle against a reference model plus literal vectors.

module tb_logic_gate_unit;

    logic        clk;
    logic        rst;

    logic        v1;
    logic [0:0]  a1, b1;
    logic [0:0]  and1, nand1, nor1;
    logic        ov1;

    logic        v16;
    logic [15:0] a16, b16;
    logic [15:0] and16, nand16, nor16;
    logic        ov16;

    int errors = 0;
    int checks = 0;
    bit check_en = 0;

    // Reference model state: last accepted pair, whether one exists since reset.
    logic [15:0] m_a, m_b;
    bit          m_cap;
    bit          m_v;

    logic_gate_unit #(.WIDTH(1)) u1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .o_and     (and1),
        .o_nand    (nand1),
        .o_nor     (nor1),
        .out_valid (ov1)
    );

    logic_gate_unit #(.WIDTH(16)) u16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v16),
        .a         (a16),
        .b         (b16),
        .o_and     (and16),
        .o_nand    (nand16),
        .o_nor     (nor16),
        .out_valid (ov16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cap = 0;
            m_v   = 0;
        end else begin
            if (v16) begin
                m_a   = a16;
                m_b   = b16;
                m_cap = 1;
            end
            m_v = v16;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp_and",  and16,  m_cap ? (m_a & m_b)    : 16'h0);
            chk("cmp_nand", nand16, m_cap ? ~(m_a & m_b)   : 16'h0);
            chk("cmp_nor",  nor16,  m_cap ? ~(m_a | m_b)   : 16'h0);
            chk("cmp_valid", {15'd0, ov16}, {15'd0, m_v});
            if (ov16) begin
                chk("inv_nand", nand16, ~and16);
                chk("inv_nor_and", and16 & nor16, 16'h0);
            end
        end
    end

    // Inputs change 1 time unit after a rising edge; the task returns just after the capture edge.
    task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b);
        v16 = v;
        a16 = a;
        b16 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic out16(input string n, input logic [15:0] ea, input logic [15:0] en,
                         input logic [15:0] eo, input logic ev);
        chk({n, "_and"},  and16,  ea);
        chk({n, "_nand"}, nand16, en);
        chk({n, "_nor"},  nor16,  eo);
        chk({n, "_valid"}, {15'd0, ov16}, {15'd0, ev});
    endtask

    logic [1:0] tt_ab   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [2:0] tt_exp  [4] = '{3'b011, 3'b010, 3'b010, 3'b100};

    initial begin
        rst = 1'b1;
        v1 = 0; a1 = 0; b1 = 0;
        v16 = 0; a16 = 0; b16 = 0;
        repeat (2) @(posedge clk);
        #1;
        out16("reset", 16'h0, 16'h0, 16'h0, 1'b0);
        chk("reset_w1", {12'd0, and1, nand1, nor1, ov1}, 16'h0);
        rst = 1'b0;
        check_en = 1;

        // WIDTH=1 exhaustive truth table on consecutive edges
        for (int i = 0; i < 4; i++) begin
            v1 = 1'b1;
            a1 = tt_ab[i][1];
            b1 = tt_ab[i][0];
            @(posedge clk);
            #1;
            chk("tt_w1", {12'd0, and1, nand1, nor1, ov1}, {12'd0, tt_exp[i], 1'b1});
        end
        v1 = 1'b0;

        // Vector pattern
        drive16(1, 16'h00F0, 16'h00CC);
        out16("vec", 16'h00C0, 16'hFF3F, 16'hFF03, 1'b1);

        // Hold with random operand churn
        drive16(1, 16'h00FF, 16'h000F);
        out16("hold_cap", 16'h000F, 16'hFFF0, 16'hFF00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive16(0, 16'($urandom), 16'($urandom));
            out16("hold", 16'h000F, 16'hFFF0, 16'hFF00, 1'b0);
        end

        // Async reset mid-stream
        drive16(1, 16'h1234, 16'hFF00);
        drive16(1, 16'hAAAA, 16'h5555);
        out16("pre_rst", 16'h0000, 16'hFFFF, 16'h0000, 1'b1);
        v16 = 1; a16 = 16'hFFFF; b16 = 16'hFFFF;
        #2 rst = 1'b1;
        #1;
        out16("rst_async", 16'h0, 16'h0, 16'h0, 1'b0);
        @(posedge clk);
        #1;
        out16("rst_hold", 16'h0, 16'h0, 16'h0, 1'b0);
        rst = 1'b0;
        drive16(1, 16'hF00F, 16'hFF00);
        out16("post_rst", 16'hF000, 16'h0FFF, 16'h00F0, 1'b1);

        // Random stream, mostly valid, checked by the model each cycle
        for (int i = 0; i < 1000; i++)
            drive16(1, 16'($urandom), 16'($urandom));
        for (int i = 0; i < 200; i++)
            drive16(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
        drive16(0, 16'h0, 16'h0);
        @(negedge clk);
        #1;
        check_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
